pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle CPU. It replaces the purely combinational next-PC adder with a registered PC. It adds stall, jump-register, exception entry/return with a saved EPC, a misaligned-jump-register trap, and a retired-instruction counter. It sits between instruction fetch and the control/ALU outputs. Its `pc_out` drives instruction memory and the debug unit.

---
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_unit.sv | 131 +++++++++++++
 tb/tb_pc_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Control and status bundle between the CPU datapath (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic              stall;
  logic              branch;
  logic              bne;
  logic              zero;
  logic              jump;
  logic              jr;
  logic [WIDTH-1:0]  ex_imm;
  logic [25:0]       addr;
  logic [WIDTH-1:0]  jr_target;
  logic              exc;
  logic              eret;

  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  next_pc;
  logic [WIDTH-1:0]  epc_out;
  logic              in_exc;
  logic [1:0]        exc_cause;
  logic              exc_masked;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stall, branch, bne, zero, jump, jr, ex_imm, addr, jr_target, exc, eret,
    input  pc_out, next_pc, epc_out, in_exc, exc_cause, exc_masked, retired
  );

  modport slave (
    input  stall, branch, bne, zero, jump, jr, ex_imm, addr, jr_target, exc, eret,
    output pc_out, next_pc, epc_out, in_exc, exc_cause, exc_masked, retired
  );
endinterface

// File: rtl/pc_unit.sv
// Registered program counter with stall, jr, exception entry/return, EPC and a
// retired-instruction counter. Next-state selection follows a fixed priority list.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]      EXC_VECTOR = 32'h0000_0180,
  parameter int               CNT_W      = 32
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  typedef enum logic {S_RUN, S_HANDLER} state_t;

  localparam logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VECTOR);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_reg, pc_nxt;
  logic [WIDTH-1:0] epc_reg, epc_nxt;
  logic [1:0]       cause_reg, cause_nxt;
  logic             masked_reg, masked_nxt;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;
  logic             take_br;
  logic             mis;
  logic             in_exc;

  assign in_exc    = (state == S_HANDLER);
  assign pc4       = pc_reg + WIDTH'(4);
  assign br_target = pc4 + (bus.ex_imm << 2);
  assign take_br   = bus.branch & (bus.zero ^ bus.bne);
  assign mis       = bus.jr & (bus.jr_target[1:0] != 2'b00);

  // At the minimum width there are no upper PC bits left to carry into a jump.
  generate
    if (WIDTH > 28) begin : g_jmp_wide
      assign jmp_target = {pc4[WIDTH-1:28], bus.addr, 2'b00};
    end else begin : g_jmp_narrow
      assign jmp_target = {bus.addr, 2'b00};
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_reg;
    epc_nxt    = epc_reg;
    cause_nxt  = cause_reg;
    masked_nxt = 1'b0;
    retire     = 1'b0;

    if (bus.exc && !in_exc) begin
      state_nxt = S_HANDLER;
      pc_nxt    = EXC_VEC;
      epc_nxt   = pc_reg;
      cause_nxt = 2'b01;
    end else begin
      if (bus.exc) begin
        masked_nxt = 1'b1;
      end
      if (!bus.stall) begin
        if (bus.eret) begin
          retire = 1'b1;
          if (in_exc) begin
            pc_nxt    = epc_reg;
            state_nxt = S_RUN;
          end else begin
            pc_nxt = pc4;
          end
        end else if (mis) begin
          // A misaligned target inside the handler cannot nest, so it retires as a no-op.
          if (!in_exc) begin
            state_nxt = S_HANDLER;
            pc_nxt    = EXC_VEC;
            epc_nxt   = pc_reg;
            cause_nxt = 2'b10;
          end else begin
            masked_nxt = 1'b1;
            pc_nxt     = pc4;
            retire     = 1'b1;
          end
        end else if (bus.jr) begin
          pc_nxt = bus.jr_target;
          retire = 1'b1;
        end else if (bus.jump) begin
          pc_nxt = jmp_target;
          retire = 1'b1;
        end else if (take_br) begin
          pc_nxt = br_target;
          retire = 1'b1;
        end else begin
          pc_nxt = pc4;
          retire = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      pc_reg      <= RESET_PC;
      epc_reg     <= '0;
      cause_reg   <= 2'b00;
      masked_reg  <= 1'b0;
      retired_reg <= '0;
    end else begin
      state      <= state_nxt;
      pc_reg     <= pc_nxt;
      epc_reg    <= epc_nxt;
      cause_reg  <= cause_nxt;
      masked_reg <= masked_nxt;
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pc_out     = pc_reg;
  assign bus.next_pc    = rst ? RESET_PC : pc_nxt;
  assign bus.epc_out    = epc_reg;
  assign bus.in_exc     = in_exc;
  assign bus.exc_cause  = cause_reg;
  assign bus.exc_masked = masked_reg;
  assign bus.retired    = retired_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one task per feature, expected values hand-computed.
module tb_pc_unit;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [CNT_W-1:0] exp_ret;

  pc_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pc_unit #(
    .WIDTH(WIDTH),
    .RESET_PC(32'h0),
    .EXC_VECTOR(32'h0000_0180),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task clear_inputs();
    bus.stall = 0; bus.branch = 0; bus.bne = 0; bus.zero = 0;
    bus.jump = 0; bus.jr = 0; bus.ex_imm = '0; bus.addr = '0;
    bus.jr_target = '0; bus.exc = 0; bus.eret = 0;
  endtask

  // Advance one rising edge and sample 1ns later; track expected retirements.
  task tick(input bit retires);
    @(posedge clk);
    #1;
    if (retires) exp_ret = exp_ret + 1'b1;
  endtask

  task set_pc(input logic [WIDTH-1:0] target);
    clear_inputs();
    bus.jr = 1; bus.jr_target = target;
    tick(1);
    clear_inputs();
  endtask

  task test_reset();
    clear_inputs();
    rst = 1;
    exp_ret = '0;
    @(negedge clk); rst = 0;
    tick(1); tick(1);
    #2; rst = 1; #1;
    n_cmp++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc: got %h want %h", bus.pc_out, 32'h0); end
    n_cmp++; if (bus.next_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_next_pc: got %h want %h", bus.next_pc, 32'h0); end
    n_cmp++; if (bus.retired !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_retired: got %0d want 0", bus.retired); end
    n_cmp++; if ({bus.in_exc, bus.exc_cause, bus.exc_masked} !== 4'b0) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 0000", {bus.in_exc, bus.exc_cause, bus.exc_masked}); end
    n_cmp++; if (bus.epc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_epc: got %h want 0", bus.epc_out); end
    exp_ret = '0;
    @(negedge clk); rst = 0;
    tick(1); tick(1); tick(1);
    n_cmp++; if (bus.pc_out !== 32'h0C) begin n_fail++; $display("[TB] FAIL adv_pc: got %h want %h", bus.pc_out, 32'h0C); end
    n_cmp++; if (bus.retired !== 4'd3) begin n_fail++; $display("[TB] FAIL adv_retired: got %0d want 3", bus.retired); end
  endtask

  task test_branch_jump();
    set_pc(32'h100);
    bus.branch = 1; bus.zero = 1; bus.ex_imm = 32'hFFFF_FFFE;
    #1;
    n_cmp++; if (bus.next_pc !== 32'hFC) begin n_fail++; $display("[TB] FAIL br_next_pc: got %h want %h", bus.next_pc, 32'hFC); end
    tick(1);
    n_cmp++; if (bus.pc_out !== 32'hFC) begin n_fail++; $display("[TB] FAIL br_taken: got %h want %h", bus.pc_out, 32'hFC); end
    set_pc(32'h100);
    bus.branch = 1; bus.zero = 1; bus.bne = 1; bus.ex_imm = 32'hFFFF_FFFE;
    tick(1);
    n_cmp++; if (bus.pc_out !== 32'h104) begin n_fail++; $display("[TB] FAIL bne_not_taken: got %h want %h", bus.pc_out, 32'h104); end
    set_pc(32'h1000_0000);
    bus.jump = 1; bus.addr = 26'h40; bus.branch = 1; bus.zero = 1; bus.ex_imm = 32'h10;
    tick(1);
    n_cmp++; if (bus.pc_out !== 32'h1000_0100) begin n_fail++; $display("[TB] FAIL jump_over_br: got %h want %h", bus.pc_out, 32'h1000_0100); end
    clear_inputs();
    bus.jr = 1; bus.jr_target = 32'h0000_2000; bus.jump = 1; bus.addr = 26'h40;
    tick(1);
    n_cmp++; if (bus.pc_out !== 32'h2000) begin n_fail++; $display("[TB] FAIL jr_over_jump: got %h want %h", bus.pc_out, 32'h2000); end
    clear_inputs();
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("[TB] FAIL br_retired: got %0d want %0d", bus.retired, exp_ret); end
  endtask

  task test_stall();
    set_pc(32'h20);
    bus.stall = 1; bus.jump = 1; bus.addr = 26'h3;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.next_pc !== 32'h20) begin n_fail++; $display("[TB] FAIL stall_next_pc[%0d]: got %h want %h", i, bus.next_pc, 32'h20); end
      tick(0);
      n_cmp++; if (bus.pc_out !== 32'h20) begin n_fail++; $display("[TB] FAIL stall_pc[%0d]: got %h want %h", i, bus.pc_out, 32'h20); end
      n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("[TB] FAIL stall_retired[%0d]: got %0d want %0d", i, bus.retired, exp_ret); end
    end
    clear_inputs();
  endtask

  task test_exception();
    set_pc(32'h44);
    bus.stall = 1; bus.exc = 1;
    tick(0);
    n_cmp++; if (bus.pc_out !== 32'h180) begin n_fail++; $display("[TB] FAIL exc_pc: got %h want %h", bus.pc_out, 32'h180); end
    n_cmp++; if (bus.epc_out !== 32'h44) begin n_fail++; $display("[TB] FAIL exc_epc: got %h want %h", bus.epc_out, 32'h44); end
    n_cmp++; if ({bus.in_exc, bus.exc_cause} !== 3'b101) begin n_fail++; $display("[TB] FAIL exc_state: got %b want 101", {bus.in_exc, bus.exc_cause}); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("[TB] FAIL exc_retired: got %0d want %0d", bus.retired, exp_ret); end
    clear_inputs();
    bus.exc = 1;
    tick(1);
    n_cmp++; if ({bus.exc_masked, bus.pc_out} !== {1'b1, 32'h184}) begin n_fail++; $display("[TB] FAIL mask_pulse: got %b/%h want 1/%h", bus.exc_masked, bus.pc_out, 32'h184); end
    n_cmp++; if (bus.epc_out !== 32'h44) begin n_fail++; $display("[TB] FAIL mask_epc: got %h want %h", bus.epc_out, 32'h44); end
    clear_inputs();
    tick(1);
    n_cmp++; if ({bus.exc_masked, bus.pc_out} !== {1'b0, 32'h188}) begin n_fail++; $display("[TB] FAIL mask_clear: got %b/%h want 0/%h", bus.exc_masked, bus.pc_out, 32'h188); end
    bus.eret = 1;
    tick(1);
    n_cmp++; if ({bus.in_exc, bus.pc_out} !== {1'b0, 32'h44}) begin n_fail++; $display("[TB] FAIL eret: got %b/%h want 0/%h", bus.in_exc, bus.pc_out, 32'h44); end
    clear_inputs();
  endtask

  task test_misaligned();
    set_pc(32'h50);
    bus.jr = 1; bus.jr_target = 32'h202;
    tick(0);
    n_cmp++; if (bus.pc_out !== 32'h180) begin n_fail++; $display("[TB] FAIL mis_pc: got %h want %h", bus.pc_out, 32'h180); end
    n_cmp++; if ({bus.epc_out, bus.exc_cause, bus.in_exc} !== {32'h50, 2'b10, 1'b1}) begin n_fail++; $display("[TB] FAIL mis_state: got %h/%b/%b want 00000050/10/1", bus.epc_out, bus.exc_cause, bus.in_exc); end
    tick(1);
    n_cmp++; if ({bus.exc_masked, bus.pc_out} !== {1'b1, 32'h184}) begin n_fail++; $display("[TB] FAIL mis_nested: got %b/%h want 1/%h", bus.exc_masked, bus.pc_out, 32'h184); end
    n_cmp++; if ({bus.epc_out, bus.exc_cause} !== {32'h50, 2'b10}) begin n_fail++; $display("[TB] FAIL mis_nested_epc: got %h/%b want 00000050/10", bus.epc_out, bus.exc_cause); end
    clear_inputs();
    bus.eret = 1;
    tick(1);
    n_cmp++; if ({bus.in_exc, bus.pc_out} !== {1'b0, 32'h50}) begin n_fail++; $display("[TB] FAIL mis_eret: got %b/%h want 0/%h", bus.in_exc, bus.pc_out, 32'h50); end
    clear_inputs();
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("[TB] FAIL mis_retired: got %0d want %0d", bus.retired, exp_ret); end
  endtask

  task test_wrap();
    set_pc(32'hFFFF_FFFC);
    tick(1);
    n_cmp++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL pc_wrap: got %h want 0", bus.pc_out); end
    bus.eret = 1;
    tick(1);
    n_cmp++; if ({bus.in_exc, bus.pc_out} !== {1'b0, 32'h4}) begin n_fail++; $display("[TB] FAIL eret_noop: got %b/%h want 0/%h", bus.in_exc, bus.pc_out, 32'h4); end
    clear_inputs();
    @(negedge clk); rst = 1; #1; rst = 0;
    exp_ret = '0;
    for (int i = 0; i < 15; i++) tick(1);
    n_cmp++; if (bus.retired !== 4'd15) begin n_fail++; $display("[TB] FAIL cnt_top: got %0d want 15", bus.retired); end
    tick(1);
    n_cmp++; if (bus.retired !== 4'd0) begin n_fail++; $display("[TB] FAIL cnt_wrap: got %0d want 0", bus.retired); end
    n_cmp++; if (bus.pc_out !== 32'h40) begin n_fail++; $display("[TB] FAIL cnt_pc: got %h want %h", bus.pc_out, 32'h40); end
  endtask

  task test_back_to_back();
    bus.exc = 1;
    tick(0);
    n_cmp++; if ({bus.in_exc, bus.epc_out} !== {1'b1, 32'h40}) begin n_fail++; $display("[TB] FAIL b2b_enter: got %b/%h want 1/%h", bus.in_exc, bus.epc_out, 32'h40); end
    bus.eret = 1;
    tick(1);
    n_cmp++; if ({bus.exc_masked, bus.in_exc, bus.pc_out} !== {2'b10, 32'h40}) begin n_fail++; $display("[TB] FAIL b2b_exc_eret: got %b/%b/%h want 1/0/%h", bus.exc_masked, bus.in_exc, bus.pc_out, 32'h40); end
    clear_inputs();
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("[TB] FAIL b2b_retired: got %0d want %0d", bus.retired, exp_ret); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_ret = '0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_branch_jump();
    test_stall();
    test_exception();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
